// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register file write port
// Grants one writeback source per cycle and registers the winning write toward the register file.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32,
   parameter int AW      = 5,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*AW-1:0]      req_rd,
   input  logic [NUM_REQ*XLEN-1:0]    req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       wb_stall,
   output logic                       reg_we,
   output logic [AW-1:0]              rd,
   output logic [XLEN-1:0]            wd,
   output logic [$clog2(NUM_REQ)-1:0] wb_src,
   output logic [CNT_W-1:0]           conflict_cnt
);

   localparam int SW = $clog2(NUM_REQ);

   logic [SW-1:0]   ptr;
   logic [SW-1:0]   grant_idx;
   logic [SW-1:0]   next_ptr;
   logic [SW:0]     cand;
   logic            grant_any;
   logic            seen;
   logic            multi;
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_data;

   // Search from ptr upward with wrap; the extra bit of cand absorbs the overflow before wrapping.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (SW+1)'(k);
         if (cand >= (SW+1)'(NUM_REQ)) begin
            cand = cand - (SW+1)'(NUM_REQ);
         end
         if (!grant_any && req_valid[cand[SW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[SW-1:0];
         end
      end
      if (reset || wb_stall) begin
         grant_any = 1'b0;
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = grant_any && (grant_idx == SW'(i));
      end
   end

   always_comb begin
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i]) begin
            if (seen) begin
               multi = 1'b1;
            end
            seen = 1'b1;
         end
      end
   end

   assign sel_rd   = req_rd[int'(grant_idx)*AW +: AW];
   assign sel_data = req_data[int'(grant_idx)*XLEN +: XLEN];
   assign next_ptr = (grant_idx == SW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr          <= '0;
         reg_we       <= 1'b0;
         rd           <= '0;
         wd           <= '0;
         wb_src       <= '0;
         conflict_cnt <= '0;
      end else begin
         if (grant_any) begin
            ptr    <= next_ptr;
            rd     <= sel_rd;
            wd     <= sel_data;
            wb_src <= grant_idx;
            // x0 is hardwired zero: the handshake completes but nothing is written.
            reg_we <= (sel_rd != '0);
         end else begin
            reg_we <= 1'b0;
         end
         if (multi && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
// A second instance with a 4-bit counter exercises saturation on the same stimulus.
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [1:0]  src;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [14:0] req_rd = '0;
   logic [95:0] req_data = '0;
   logic        wb_stall = 1'b0;
   logic [2:0]  req_ready;
   logic        reg_we;
   logic [4:0]  rd;
   logic [31:0] wd;
   logic [1:0]  wb_src;
   logic [15:0] conflict_cnt;
   logic [2:0]  req_ready4;
   logic        reg_we4;
   logic [4:0]  rd4;
   logic [31:0] wd4;
   logic [1:0]  wb_src4;
   logic [3:0]  conflict_cnt4;

   logic [4:0]  rd_v [3];
   logic [31:0] wd_v [3];
   wr_t         sb [$];
   wr_t         last;
   int          exp_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .AW(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
      .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
      .reg_we(reg_we), .rd(rd), .wd(wd), .wb_src(wb_src), .conflict_cnt(conflict_cnt)
   );

   regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .AW(5), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
      .req_data(req_data), .req_ready(req_ready4), .wb_stall(wb_stall),
      .reg_we(reg_we4), .rd(rd4), .wd(wd4), .wb_src(wb_src4), .conflict_cnt(conflict_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive, check the combinational grant, push the expected write, then pop after the edge.
   task automatic step(input logic [2:0] v, input logic st, input logic rs, input int g);
      wr_t        e;
      wr_t        o;
      logic [2:0] exp_ready;
      req_valid = v;
      wb_stall  = st;
      reset     = rs;
      req_rd    = {rd_v[2], rd_v[1], rd_v[0]};
      req_data  = {wd_v[2], wd_v[1], wd_v[0]};
      #1;
      exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (rs) begin
         last    = '0;
         exp_cnt = 0;
      end else begin
         if (g >= 0) begin
            last.rd  = rd_v[g];
            last.wd  = wd_v[g];
            last.src = 2'(g);
            last.we  = (rd_v[g] != 5'd0);
         end else begin
            last.we = 1'b0;
         end
         if ($countones(v) >= 2) exp_cnt++;
      end
      e = last;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         o = sb.pop_front();
         chk("reg_we", 32'(reg_we), 32'(o.we));
         chk("rd", 32'(rd), 32'(o.rd));
         chk("wd", wd, o.wd);
         chk("wb_src", 32'(wb_src), 32'(o.src));
      end
      chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
      chk("conflict_cnt4", 32'(conflict_cnt4), (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
   endtask

   initial begin
      last = '0;
      rd_v[0] = 5'd1;  rd_v[1] = 5'd2;  rd_v[2] = 5'd3;
      wd_v[0] = 32'h0000_0100; wd_v[1] = 32'h0000_0200; wd_v[2] = 32'h0000_0300;

      // Reset with requests pending: nothing granted, then an idle stretch.
      step(3'b111, 1'b0, 1'b1, -1);
      step(3'b000, 1'b0, 1'b1, -1);
      for (int i = 0; i < 5; i++) step(3'b000, 1'b0, 1'b0, -1);

      // All three valid: strict rotation 0,1,2,0,1,2.
      for (int i = 0; i < 6; i++) step(3'b111, 1'b0, 1'b0, i % 3);
      chk("cnt_after_rotation", 32'(conflict_cnt), 32'd6);

      // Single requester 1: x0 write completes without reg_we, then a real write; no bubbles.
      rd_v[1] = 5'd0;  wd_v[1] = 32'hDEAD_BEEF;
      step(3'b010, 1'b0, 1'b0, 1);
      rd_v[1] = 5'd7;
      step(3'b010, 1'b0, 1'b0, 1);
      chk("rd7", 32'(rd), 32'd7);
      chk("wd_deadbeef", wd, 32'hDEAD_BEEF);

      // ptr sits at 2; a grant to 2 wraps it back to 0 ahead of the stall test.
      rd_v[0] = 5'd4;  rd_v[2] = 5'd5;
      wd_v[0] = 32'h1111_0000; wd_v[2] = 32'h2222_0000;
      step(3'b100, 1'b0, 1'b0, 2);
      for (int i = 0; i < 3; i++) step(3'b101, 1'b1, 1'b0, -1);
      step(3'b101, 1'b0, 1'b0, 0);
      step(3'b101, 1'b0, 1'b0, 2);

      // Move ptr to 1, then reset in the cycle requester 2 (rd=9) would be granted.
      rd_v[2] = 5'd9;  wd_v[2] = 32'h9999_0009;
      step(3'b011, 1'b0, 1'b0, 0);
      step(3'b100, 1'b0, 1'b1, -1);
      step(3'b111, 1'b0, 1'b0, 0);

      // Sustained contention saturates the 4-bit counter at 15.
      for (int i = 0; i < 20; i++) step(3'b111, 1'b0, 1'b0, (i + 1) % 3);
      chk("cnt4_saturated", 32'(conflict_cnt4), 32'd15);
      chk("cnt16_total", 32'(conflict_cnt), 32'd21);

      step(3'b000, 1'b0, 1'b0, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
